multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Next-generation control for the RV32I core: replaces the single-cycle opcode decoder with a multi-cycle FSM that shares one ALU and one memory port across fetch, execute, memory and writeback.
- Adds a variable-latency memory handshake, LUI/AUIPC support, an illegal-opcode trap and a memory timeout.
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
- SUPPORT_UPPER, 1, 1 = LUI (0110111) and AUIPC (0010111) legal; 0 = both trap as illegal.
- MEM_TIMEOUT, 16, max wait cycles in any memory state before trap; 0 disables the timeout.
- TO_W, 5, timeout counter width; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- opcode  in  7  IR[6:0], valid from DECODE onward
- branch_taken  in  1  comparator result from the datapath, valid in BRANCH
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, qualified by mem_req
- ir_write  out  1  load IR and oldPC
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = ALU result, 1 = ALUOut register
- alu_src_a  out  2  00 PC, 01 oldPC, 10 rs1, 11 zero
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 sub/compare, 10 funct R-type, 11 funct I-type
- reg_write  out  1  register file write enable
- result_src  out  2  00 ALUOut, 01 memory read data, 10 ALU result
- illegal_instr  out  1  sticky trap flag: illegal opcode
- bus_error  out  1  sticky trap flag: memory timeout
- state_o  out  4  current state encoding, for debug

Behaviour:
- Reset and output style:
  - Asynchronous reset: state goes to FETCH, timeout counter and both flags clear, and every output is 0 while rst_n is low, including mid-access.
  - First mem_req is asserted in the first cycle after rst_n deasserts.
  - Outputs are decoded from the current state plus mem_ready and branch_taken. Every control not listed for a state is 0.
- States and transitions:
  - FETCH: mem_req=1; alu_src_a=PC, alu_src_b=4, alu_op=add, pc_src=0. When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE. Otherwise stay in FETCH.
  - DECODE: ALUOut <= oldPC + imm (alu_src_a=01, alu_src_b=01, alu_op=add). Dispatch on opcode:
    - R-type → EXEC_R; OP-IMM → EXEC_I; load/store → MEM_ADDR; branch → BRANCH
    - JAL → JAL; JALR → JALR_ADDR; LUI/AUIPC → UPPER
    - any other opcode → TRAP with illegal_instr=1
  - EXEC_R: a=rs1, b=rs2, op=10 → ALU_WB.
  - EXEC_I: a=rs1, b=imm, op=11 → ALU_WB.
  - UPPER: a=zero (LUI) or oldPC (AUIPC), b=imm, op=add → ALU_WB.
  - ALU_WB: reg_write=1, result_src=00 → FETCH.
  - MEM_ADDR: a=rs1, b=imm, op=add. Go to MEM_READ if opcode is load, else MEM_WRITE.
  - MEM_READ: mem_req=1. Go to MEM_WB on mem_ready, otherwise hold.
  - MEM_WB: reg_write=1, result_src=01 → FETCH.
  - MEM_WRITE: mem_req=1, mem_we=1. Go to FETCH on mem_ready.
  - BRANCH: a=rs1, b=rs2, op=01; pc_src=1; pc_write=branch_taken → FETCH.
  - JAL: pc_write=1, pc_src=1; a=oldPC, b=4, op=add; reg_write=1, result_src=10 → FETCH.
  - JALR_ADDR: a=rs1, b=imm, op=add → JALR_LINK.
  - JALR_LINK: pc_write=1, pc_src=1; a=oldPC, b=4; reg_write=1, result_src=10 → FETCH.
  - TRAP: absorbing state; all controls 0; flags hold. Only reset exits.
- Latency with zero-wait memory (mem_ready high in the first request cycle):
  - R/I/U: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - JAL: 3 cycles
  - JALR: 4 cycles
  - Each memory wait cycle adds 1.
- Timeout:
  - Counter clears on entry to FETCH, MEM_READ or MEM_WRITE and increments each cycle mem_ready=0 in those states.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: go to TRAP and set bus_error=1. The access is abandoned.
  - mem_ready=1 in the same cycle that the limit is reached completes the access normally; completion wins.
- mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- Opcode only matters in DECODE and MEM_ADDR; changes elsewhere are ignored.

Decomposition:
- Shared package: opcode constants (R, LOAD, STORE, BRANCH, OP_IMM, JAL, JALR, LUI, AUIPC), state enum (4-bit), and encodings for alu_op, alu_src_a/b and result_src.
- Natural sub-module: mem_timeout_counter (clear, enable, limit → expired).

Test Plan:
- Reset, then ADD (0110011) with mem_ready tied 1 → states FETCH, DECODE, EXEC_R, ALU_WB, FETCH; reg_write=1 only in cycle 4; pc_write=1 only in cycle 1.
- LW with mem_ready low for 3 cycles in MEM_READ → 8 cycles total; result_src=01 with reg_write in MEM_WB; mem_we never 1.
- BEQ with branch_taken=1, then again with branch_taken=0 → pc_write=1 with pc_src=1 in BRANCH in the first case; pc_write=0 in the second.
- Opcode 7'b1111111 → TRAP after DECODE; illegal_instr=1 stays high for 10 cycles; mem_req stays 0.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → bus_error=1 after the 4th wait cycle. Repeat with mem_ready=1 on exactly that cycle → normal DECODE, no trap.
- rst_n pulsed low mid-MEM_WRITE → outputs 0 immediately; FETCH with mem_req=1 in the cycle after release. With SUPPORT_UPPER=0, LUI → illegal_instr=1.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM states,
// datapath select encodings and the opcode dispatch used in DECODE.
package multicycle_control_unit_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_UPPER     = 4'd4,
        S_ALU_WB    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR_ADDR = 4'd12,
        S_JALR_LINK = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT_R = 2'b10;
    localparam logic [1:0] ALU_FUNCT_I = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_IMM   = 2'b01;
    localparam logic [1:0] SRC_B_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

    function automatic state_t dispatch(input logic [6:0] opc, input logic upper_ok);
        state_t nxt;
        case (opc)
            OPC_R:                nxt = S_EXEC_R;
            OPC_OP_IMM:           nxt = S_EXEC_I;
            OPC_LOAD, OPC_STORE:  nxt = S_MEM_ADDR;
            OPC_BRANCH:           nxt = S_BRANCH;
            OPC_JAL:              nxt = S_JAL;
            OPC_JALR:             nxt = S_JALR_ADDR;
            OPC_LUI, OPC_AUIPC:   nxt = upper_ok ? S_UPPER : S_TRAP;
            default:              nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_timeout_counter.sv
// Counts memory wait cycles; expired fires in the wait cycle that would bring the
// count up to LIMIT, so at most LIMIT wait cycles are tolerated. LIMIT=0 disables it.
module multicycle_control_unit_mem_timeout_counter #(
    parameter int LIMIT = 16,
    parameter int W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && enable && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback over
// a shared ALU and memory port, with illegal-opcode and memory-timeout traps.
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter bit SUPPORT_UPPER = 1'b1,
    parameter int MEM_TIMEOUT   = 16,
    parameter int TO_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [3:0] state_o
);

    state_t state;
    state_t decode_next;
    logic   is_lui;
    logic   in_mem;
    logic   to_expired;
    ctrl_t  ctrl;

    assign in_mem      = is_mem_state(state);
    assign decode_next = dispatch(opcode, SUPPORT_UPPER);

    // Every memory state exits on mem_ready, so clearing on completion or outside
    // the memory states gives a fresh count on each entry.
    multicycle_control_unit_mem_timeout_counter #(
        .LIMIT (MEM_TIMEOUT),
        .W     (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (~in_mem | mem_ready),
        .enable  (in_mem & ~mem_ready),
        .expired (to_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            is_lui        <= 1'b0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        state <= S_DECODE;
                    end else if (to_expired) begin
                        state     <= S_TRAP;
                        bus_error <= 1'b1;
                    end
                end
                S_DECODE: begin
                    state  <= decode_next;
                    // UPPER needs LUI vs AUIPC, but opcode is only trusted here.
                    is_lui <= (opcode == OPC_LUI);
                    if (decode_next == S_TRAP) begin
                        illegal_instr <= 1'b1;
                    end
                end
                S_EXEC_R, S_EXEC_I, S_UPPER: state <= S_ALU_WB;
                S_MEM_ADDR:  state <= (opcode == OPC_LOAD) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: begin
                    if (mem_ready) begin
                        state <= S_MEM_WB;
                    end else if (to_expired) begin
                        state     <= S_TRAP;
                        bus_error <= 1'b1;
                    end
                end
                S_MEM_WRITE: begin
                    if (mem_ready) begin
                        state <= S_FETCH;
                    end else if (to_expired) begin
                        state     <= S_TRAP;
                        bus_error <= 1'b1;
                    end
                end
                S_JALR_ADDR: state <= S_JALR_LINK;
                S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR_LINK: state <= S_FETCH;
                S_TRAP:      state <= S_TRAP;
                default:     state <= S_FETCH;
            endcase
        end
    end

    // Mealy decode on state, mem_ready and branch_taken; forced quiet during reset
    // because FETCH (the reset state) would otherwise request memory.
    always_comb begin
        ctrl = '0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_req   = 1'b1;
                    ctrl.alu_src_a = SRC_A_PC;
                    ctrl.alu_src_b = SRC_B_FOUR;
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_a = SRC_A_OLDPC;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_EXEC_R: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_RS2;
                    ctrl.alu_op    = ALU_FUNCT_R;
                end
                S_EXEC_I: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_FUNCT_I;
                end
                S_UPPER: begin
                    ctrl.alu_src_a = is_lui ? SRC_A_ZERO : SRC_A_OLDPC;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_ALU_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.result_src = RES_ALUOUT;
                end
                S_MEM_ADDR, S_JALR_ADDR: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_IMM;
                    ctrl.alu_op    = ALU_ADD;
                end
                S_MEM_READ: ctrl.mem_req = 1'b1;
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.result_src = RES_MEM;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.mem_we  = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a = SRC_A_RS1;
                    ctrl.alu_src_b = SRC_B_RS2;
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.pc_src    = 1'b1;
                    ctrl.pc_write  = branch_taken;
                end
                S_JAL, S_JALR_LINK: begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_src     = 1'b1;
                    ctrl.alu_src_a  = SRC_A_OLDPC;
                    ctrl.alu_src_b  = SRC_B_FOUR;
                    ctrl.alu_op     = ALU_ADD;
                    ctrl.reg_write  = 1'b1;
                    ctrl.result_src = RES_ALU;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign pc_src     = ctrl.pc_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_write  = ctrl.reg_write;
    assign result_src = ctrl.result_src;
    assign state_o    = state;

endmodule
